// File: rtl/count_wrap_monitor_if.sv
// Signal bundle between the up/down counter side and count_wrap_monitor.
// slave is the monitor's view; master is the driver/readout view.
interface count_wrap_monitor_if #(
    parameter int CNT_W = 4,
    parameter int EXT_W = 4
);
    logic                   x;
    logic [CNT_W-1:0]       q;
    logic                   clr;
    logic                   valid;
    logic                   ovf;
    logic                   unf;
    logic                   step_err;
    logic                   sat;
    logic [EXT_W-1:0]       ext;
    logic [EXT_W+CNT_W-1:0] value;

    modport master (
        output x, q, clr,
        input  valid, ovf, unf, step_err, sat, ext, value
    );

    modport slave (
        input  x, q, clr,
        output valid, ovf, unf, step_err, sat, ext, value
    );
endinterface

// File: rtl/count_wrap_monitor.sv
// Tracks a negedge-clocked up/down counter, extends it with a wrap count and flags illegal steps.
// Optional CWM_SATURATE_EN: ext saturates at 0 / all-ones and sets a sticky sat flag.
//
// state    | meaning
// UNPRIMED | no history yet; next edge loads q_prev/x_prev
// TRACK    | classifying each sampled step against the history
// FAULT    | illegal step seen; ext frozen, history still follows q
module count_wrap_monitor #(
    parameter int CNT_W = 4,
    parameter int EXT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    count_wrap_monitor_if.slave  bus
);
    typedef enum logic [1:0] {
        UNPRIMED = 2'd0,
        TRACK    = 2'd1,
        FAULT    = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] q_prev;
    logic             x_prev;
    logic [EXT_W-1:0] ext;
    logic             valid;
    logic             ovf;
    logic             unf;
    logic             step_err;
`ifdef CWM_SATURATE_EN
    logic             sat;
`endif

    logic [CNT_W-1:0] q_inc;
    logic [CNT_W-1:0] q_dec;
    logic             step_up;
    logic             step_dn;
    logic             bad_step;

    always_comb begin
        q_inc    = q_prev + CNT_W'(1);
        q_dec    = q_prev - CNT_W'(1);
        step_up  = 1'b0;
        step_dn  = 1'b0;
        bad_step = 1'b0;
        if (bus.q == q_prev) begin
            step_up = 1'b0;
        end else if (CNT_W == 1) begin
            // a 1-bit toggle is ambiguous, so the recorded direction decides it
            step_up = ~x_prev;
            step_dn = x_prev;
        end else if (bus.q == q_inc) begin
            step_up  = 1'b1;
            bad_step = x_prev;
        end else if (bus.q == q_dec) begin
            step_dn  = 1'b1;
            bad_step = ~x_prev;
        end else begin
            bad_step = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.clr) begin
            state    <= UNPRIMED;
            q_prev   <= '0;
            x_prev   <= 1'b0;
            ext      <= '0;
            valid    <= 1'b0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            step_err <= 1'b0;
`ifdef CWM_SATURATE_EN
            sat      <= 1'b0;
`endif
        end else begin
            ovf    <= 1'b0;
            unf    <= 1'b0;
            q_prev <= bus.q;
            x_prev <= bus.x;
            valid  <= 1'b1;
            case (state)
                UNPRIMED: state <= TRACK;
                TRACK: begin
                    if (bad_step) begin
                        step_err <= 1'b1;
                        state    <= FAULT;
                    end else if (step_up && (q_prev == '1)) begin
                        ovf <= 1'b1;
`ifdef CWM_SATURATE_EN
                        if (ext == '1) sat <= 1'b1;
                        else           ext <= ext + EXT_W'(1);
`else
                        ext <= ext + EXT_W'(1);
`endif
                    end else if (step_dn && (q_prev == '0)) begin
                        unf <= 1'b1;
`ifdef CWM_SATURATE_EN
                        if (ext == '0) sat <= 1'b1;
                        else           ext <= ext - EXT_W'(1);
`else
                        ext <= ext - EXT_W'(1);
`endif
                    end
                end
                FAULT:   state <= FAULT;
                default: state <= UNPRIMED;
            endcase
        end
    end

    assign bus.valid    = valid;
    assign bus.ovf      = ovf;
    assign bus.unf      = unf;
    assign bus.step_err = step_err;
    assign bus.ext      = ext;
    // ext and q_prev share one edge, so value is never torn across a wrap
    assign bus.value    = {ext, q_prev};
`ifdef CWM_SATURATE_EN
    assign bus.sat      = sat;
`else
    assign bus.sat      = 1'b0;
`endif
endmodule

// File: tb/tb_count_wrap_monitor.sv
// Directed self-checking bench for count_wrap_monitor (CNT_W=4, EXT_W=4).
module tb_count_wrap_monitor;
`ifdef CWM_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    count_wrap_monitor_if #(.CNT_W(4), .EXT_W(4)) bus ();

    count_wrap_monitor #(.CNT_W(4), .EXT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs change on negedge like the real counter; outputs read 1 unit after posedge
    task automatic drive(input logic [3:0] qv, input logic xv);
        @(negedge clk);
        rst_n   = 1'b1;
        bus.clr = 1'b0;
        bus.q   = qv;
        bus.x   = xv;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] qv);
        @(negedge clk);
        rst_n   = 1'b0;
        bus.clr = 1'b0;
        bus.q   = qv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        do_reset(4'd0);
        n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.valid); end
        n_checks++; if ({bus.ovf, bus.unf, bus.step_err, bus.sat} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {bus.ovf, bus.unf, bus.step_err, bus.sat}); end
        n_checks++; if (bus.value !== 8'h00) begin n_fail++; $display("FAIL reset_value got %h want 00", bus.value); end
    endtask

    task automatic test_up_wrap;
        do_reset(4'd0);
        drive(4'd14, 1'b0);
        n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL up_valid got %b want 1", bus.valid); end
        drive(4'd15, 1'b0);
        n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL up_no_ovf got %b want 0", bus.ovf); end
        drive(4'd0, 1'b0);
        n_checks++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL up_ovf got %b want 1", bus.ovf); end
        n_checks++; if (bus.value !== 8'h10) begin n_fail++; $display("FAIL up_wrap_value got %h want 10", bus.value); end
        drive(4'd1, 1'b0);
        n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL up_ovf_pulse got %b want 0", bus.ovf); end
        n_checks++; if (bus.ext !== 4'd1) begin n_fail++; $display("FAIL up_ext got %h want 1", bus.ext); end
        n_checks++; if (bus.value !== 8'h11) begin n_fail++; $display("FAIL up_value got %h want 11", bus.value); end
        n_checks++; if (bus.step_err !== 1'b0) begin n_fail++; $display("FAIL up_err got %b want 0", bus.step_err); end
        drive(4'd1, 1'b0);
        n_checks++; if (bus.value !== 8'h11) begin n_fail++; $display("FAIL hold_value got %h want 11", bus.value); end
    endtask

    task automatic test_down_wrap;
        logic [3:0] want_ext;
        want_ext = SAT_EN ? 4'h0 : 4'hF;
        do_reset(4'd0);
        drive(4'd1, 1'b1);
        drive(4'd0, 1'b1);
        n_checks++; if (bus.unf !== 1'b0) begin n_fail++; $display("FAIL dn_no_unf got %b want 0", bus.unf); end
        drive(4'd15, 1'b1);
        n_checks++; if (bus.unf !== 1'b1) begin n_fail++; $display("FAIL dn_unf got %b want 1", bus.unf); end
        n_checks++; if (bus.ext !== want_ext) begin n_fail++; $display("FAIL dn_ext got %h want %h", bus.ext, want_ext); end
        n_checks++; if (bus.value !== {want_ext, 4'hF}) begin n_fail++; $display("FAIL dn_value got %h want %h", bus.value, {want_ext, 4'hF}); end
        n_checks++; if (bus.sat !== SAT_EN) begin n_fail++; $display("FAIL dn_sat got %b want %b", bus.sat, SAT_EN); end
        n_checks++; if (bus.step_err !== 1'b0) begin n_fail++; $display("FAIL dn_err got %b want 0", bus.step_err); end
        drive(4'd14, 1'b1);
        n_checks++; if (bus.unf !== 1'b0) begin n_fail++; $display("FAIL dn_unf_pulse got %b want 0", bus.unf); end
    endtask

    task automatic test_fault_clr;
        int pulses;
        pulses = 0;
        do_reset(4'd0);
        drive(4'd3, 1'b0);
        drive(4'd6, 1'b0);
        n_checks++; if (bus.step_err !== 1'b1) begin n_fail++; $display("FAIL jump_err got %b want 1", bus.step_err); end
        for (int i = 7; i <= 17; i++) begin
            drive(4'(i), 1'b0);
            if (bus.ovf === 1'b1 || bus.unf === 1'b1) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL fault_pulses got %0d want 0", pulses); end
        n_checks++; if (bus.value !== 8'h01) begin n_fail++; $display("FAIL fault_value got %h want 01", bus.value); end
        @(negedge clk);
        bus.clr = 1'b1;
        bus.q   = 4'd2;
        @(posedge clk);
        #1;
        n_checks++; if ({bus.step_err, bus.valid} !== 2'b00) begin n_fail++; $display("FAIL clr_flags got %b want 00", {bus.step_err, bus.valid}); end
        n_checks++; if (bus.ext !== 4'd0) begin n_fail++; $display("FAIL clr_ext got %h want 0", bus.ext); end
        drive(4'd2, 1'b0);
        n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL clr_revalid got %b want 1", bus.valid); end
        drive(4'd3, 1'b0);
        n_checks++; if (bus.step_err !== 1'b0) begin n_fail++; $display("FAIL clr_track got %b want 0", bus.step_err); end
    endtask

    task automatic test_dir_err;
        do_reset(4'd0);
        drive(4'd5, 1'b1);
        drive(4'd6, 1'b0);
        n_checks++; if (bus.step_err !== 1'b1) begin n_fail++; $display("FAIL dir_err got %b want 1", bus.step_err); end
        n_checks++; if (bus.ext !== 4'd0) begin n_fail++; $display("FAIL dir_ext got %h want 0", bus.ext); end
        do_reset(4'd0);
        drive(4'd0, 1'b0);
        drive(4'd15, 1'b1);
        n_checks++; if ({bus.step_err, bus.unf} !== 2'b10) begin n_fail++; $display("FAIL dir_dn_err got %b want 10", {bus.step_err, bus.unf}); end
    endtask

    task automatic test_reset_mid;
        do_reset(4'd0);
        drive(4'd15, 1'b0);
        for (int i = 0; i < 80; i++) drive(4'(i), 1'b0);
        n_checks++; if (bus.ext !== 4'd5) begin n_fail++; $display("FAIL mid_ext got %h want 5", bus.ext); end
        do_reset(4'd15);
        n_checks++; if ({bus.valid, bus.ovf, bus.unf, bus.step_err, bus.sat} !== 5'b0) begin n_fail++; $display("FAIL mid_flags got %b want 00000", {bus.valid, bus.ovf, bus.unf, bus.step_err, bus.sat}); end
        n_checks++; if (bus.value !== 8'h00) begin n_fail++; $display("FAIL mid_value got %h want 00", bus.value); end
        drive(4'd0, 1'b0);
        n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL mid_first_ovf got %b want 0", bus.ovf); end
        n_checks++; if (bus.value !== 8'h00) begin n_fail++; $display("FAIL mid_first_value got %h want 00", bus.value); end
    endtask

    task automatic test_full_cycles;
        int pulses;
        logic [3:0] want_ext;
        pulses   = 0;
        want_ext = SAT_EN ? 4'hF : 4'h0;
        do_reset(4'd0);
        drive(4'd0, 1'b0);
        for (int i = 1; i <= 256; i++) begin
            drive(4'(i), 1'b0);
            if (bus.ovf === 1'b1) pulses++;
        end
        n_checks++; if (pulses !== 16) begin n_fail++; $display("FAIL full_pulses got %0d want 16", pulses); end
        n_checks++; if (bus.ext !== want_ext) begin n_fail++; $display("FAIL full_ext got %h want %h", bus.ext, want_ext); end
        n_checks++; if (bus.sat !== SAT_EN) begin n_fail++; $display("FAIL full_sat got %b want %b", bus.sat, SAT_EN); end
        n_checks++; if (bus.step_err !== 1'b0) begin n_fail++; $display("FAIL full_err got %b want 0", bus.step_err); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.clr  = 1'b0;
        bus.x    = 1'b0;
        bus.q    = 4'd0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_fault_clr();
        test_dir_err();
        test_reset_mid();
        test_full_cycles();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
